// File: rtl/c4_pkg.sv
// Shared Connect-Four constants and types for the board store and its readers.
package c4_pkg;

  localparam int unsigned NUM_COLS  = 7;
  localparam int unsigned ROWS      = 6;
  localparam int unsigned CONNECT   = 4;
  localparam int unsigned NUM_DIRS  = 4;
  localparam int unsigned COL_BITS  = 2 * ROWS;
  localparam int unsigned NUM_STEPS = NUM_COLS * ROWS * NUM_DIRS;
  localparam int unsigned IDX_W     = $clog2(NUM_STEPS);
  localparam int unsigned ANCH_W    = IDX_W - 2;
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned ROW_W     = $clog2(ROWS);
  // Wide enough for an anchor plus the longest window offset.
  localparam int unsigned POS_W     = 4;

  localparam logic [1:0] CELL_EMPTY   = 2'b00;
  localparam logic [1:0] CELL_RED     = 2'b01;
  localparam logic [1:0] CELL_YELLOW  = 2'b10;
  localparam logic [1:0] CELL_ILLEGAL = 2'b11;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_RED    = 2'b01;
  localparam logic [1:0] WIN_YELLOW = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_DU, DIR_DD} dir_t;
  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  typedef logic [CONNECT-1:0][1:0] window_t;

endpackage

// File: rtl/board_win_scanner_if.sv
// Board columns in, scan result out, between board store and game control.
interface board_win_scanner_if;
  import c4_pkg::*;

  logic                change;
  logic [COL_BITS-1:0] col1;
  logic [COL_BITS-1:0] col2;
  logic [COL_BITS-1:0] col3;
  logic [COL_BITS-1:0] col4;
  logic [COL_BITS-1:0] col5;
  logic [COL_BITS-1:0] col6;
  logic [COL_BITS-1:0] col7;
  logic [1:0]          win;
  logic                busy;
  logic                done;

  modport master (
    output change, col1, col2, col3, col4, col5, col6, col7,
    input  win, busy, done
  );

  modport slave (
    input  change, col1, col2, col3, col4, col5, col6, col7,
    output win, busy, done
  );

endinterface

// File: rtl/window_check.sv
// Flags a window whose cells are all the same player colour.
module window_check
  import c4_pkg::*;
(
  input  window_t    cells,
  output logic       hit,
  output logic [1:0] colour
);

  always_comb begin
    hit    = (cells[0] == CELL_RED) || (cells[0] == CELL_YELLOW);
    colour = cells[0];
    for (int k = 1; k < int'(CONNECT); k++) begin
      if (cells[k] != cells[0]) hit = 1'b0;
    end
  end

endmodule

// File: rtl/board_win_scanner.sv
// Snapshots the board on change, then walks every anchor/direction window one per cycle.
module board_win_scanner
  import c4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  board_win_scanner_if.slave bus
);

  state_t                             state, state_d;
  logic [IDX_W-1:0]                   idx, idx_d;
  logic                               found, found_d;
  logic [1:0]                         found_col, found_col_d;
  logic [1:0]                         win_q, win_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [NUM_COLS-1:0][COL_BITS-1:0]  snap, snap_d;

  logic [ANCH_W-1:0] anchor;
  logic [COL_W-1:0]  anc_col;
  logic [ROW_W-1:0]  anc_row;
  dir_t              dir;
  logic              step_c, row_up, row_dn;
  window_t           cells;
  logic [CONNECT-1:0] on_k;
  logic              in_board;
  logic              hit;
  logic [1:0]        colour;
  logic              new_hit;
  logic [NUM_COLS*ROWS-1:0] occ;
  logic              board_full;

  // Column-major anchor order: idx/4 walks rows within a column first.
  assign anchor  = idx[IDX_W-1:2];
  assign dir     = dir_t'(idx[1:0]);
  assign anc_col = COL_W'(anchor / ANCH_W'(ROWS));
  assign anc_row = ROW_W'(anchor % ANCH_W'(ROWS));
  assign step_c  = (dir != DIR_V);
  assign row_up  = (dir == DIR_V) || (dir == DIR_DU);
  assign row_dn  = (dir == DIR_DD);

  for (genvar k = 0; k < CONNECT; k++) begin : g_win
    logic [POS_W-1:0] cpos;
    logic [POS_W-1:0] rpos;
    logic             on;

    always_comb begin
      cpos = POS_W'(anc_col) + (step_c ? POS_W'(k) : POS_W'(0));
      rpos = POS_W'(anc_row);
      on   = 1'b1;
      if (row_up) begin
        rpos = POS_W'(anc_row) + POS_W'(k);
      end else if (row_dn) begin
        on   = (POS_W'(k) <= POS_W'(anc_row));
        rpos = POS_W'(anc_row) - POS_W'(k);
      end
      if ((cpos >= POS_W'(NUM_COLS)) || (rpos >= POS_W'(ROWS))) on = 1'b0;
    end

    assign on_k[k]  = on;
    assign cells[k] = on ? snap[cpos[COL_W-1:0]][{rpos[ROW_W-1:0], 1'b0} +: 2] : CELL_EMPTY;
  end

  assign in_board = &on_k;

  window_check u_window_check (
    .cells  (cells),
    .hit    (hit),
    .colour (colour)
  );

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_occ_c
    for (genvar r = 0; r < ROWS; r++) begin : g_occ_r
      assign occ[c*ROWS + r] = |snap[c][2*r +: 2];
    end
  end

  assign board_full = &occ;
  assign new_hit    = (state == ST_SCAN) && in_board && hit && !found;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    found_d     = found;
    found_col_d = found_col;
    win_d       = win_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    snap_d      = snap;

    case (state)
      ST_IDLE: begin
        if (bus.change) begin
          snap_d      = {bus.col7, bus.col6, bus.col5, bus.col4, bus.col3, bus.col2, bus.col1};
          idx_d       = '0;
          found_d     = 1'b0;
          found_col_d = CELL_EMPTY;
          busy_d      = 1'b1;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (new_hit) begin
          found_d     = 1'b1;
          found_col_d = colour;
        end
        if (idx == IDX_W'(NUM_STEPS - 1)) begin
          if (found_d)         win_d = found_col_d;
          else if (board_full) win_d = WIN_DRAW;
          else                 win_d = WIN_NONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      found     <= 1'b0;
      found_col <= CELL_EMPTY;
      win_q     <= WIN_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      snap      <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      found     <= found_d;
      found_col <= found_col_d;
      win_q     <= win_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      snap      <= snap_d;
    end
  end

  assign bus.win  = win_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed scenarios for board_win_scanner with hand-derived expected results.
module tb_board_win_scanner;
  import c4_pkg::*;

  logic clk = 1'b0;
  logic reset;
  board_win_scanner_if bus ();

  board_win_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] brd [NUM_COLS][ROWS];

  function automatic logic [COL_BITS-1:0] col_of(input int c);
    logic [COL_BITS-1:0] v;
    v = '0;
    for (int r = 0; r < int'(ROWS); r++) v[2*r +: 2] = brd[c][r];
    return v;
  endfunction

  task automatic clear_board();
    for (int c = 0; c < int'(NUM_COLS); c++)
      for (int r = 0; r < int'(ROWS); r++) brd[c][r] = CELL_EMPTY;
  endtask

  task automatic drive_cols();
    bus.col1 = col_of(0);
    bus.col2 = col_of(1);
    bus.col3 = col_of(2);
    bus.col4 = col_of(3);
    bus.col5 = col_of(4);
    bus.col6 = col_of(5);
    bus.col7 = col_of(6);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan();
    drive_cols();
    bus.change = 1'b1;
    step();
    bus.change = 1'b0;
  endtask

  // Cycles from accepting edge until done is seen; also counts idle gaps in busy.
  task automatic wait_done(output int cycles, output int busy_gaps);
    cycles    = 0;
    busy_gaps = 0;
    while (cycles < 400) begin
      step();
      cycles++;
      if (bus.done) break;
      if (!bus.busy) busy_gaps++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.change = 1'b0;
    clear_board();
    drive_cols();
    step();
    step();
    n_checks++; if (bus.win !== WIN_NONE) begin n_fail++; $display("FAIL reset_win got %b want %b", bus.win, WIN_NONE); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_empty();
    int cyc, gaps;
    clear_board();
    start_scan();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy_start got %b want 1", bus.busy); end
    wait_done(cyc, gaps);
    n_checks++; if (cyc != 168) begin n_fail++; $display("FAIL empty_latency got %0d want 168", cyc); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL empty_busy_gaps got %0d want 0", gaps); end
    n_checks++; if (bus.win !== WIN_NONE) begin n_fail++; $display("FAIL empty_win got %b want %b", bus.win, WIN_NONE); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_end got %b want 0", bus.busy); end
    step();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL empty_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_vertical();
    int cyc, gaps;
    clear_board();
    for (int r = 0; r < 4; r++) brd[1][r] = CELL_RED;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL vert_col2_win got %b want %b", bus.win, WIN_RED); end
    clear_board();
    for (int r = 2; r < 6; r++) brd[6][r] = CELL_YELLOW;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_YELLOW) begin n_fail++; $display("FAIL vert_col7_top_win got %b want %b", bus.win, WIN_YELLOW); end
  endtask

  task automatic test_diagonal();
    int cyc, gaps;
    clear_board();
    for (int k = 0; k < 4; k++) brd[3+k][k] = CELL_YELLOW;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_YELLOW) begin n_fail++; $display("FAIL diag_up_win got %b want %b", bus.win, WIN_YELLOW); end
    clear_board();
    for (int k = 0; k < 4; k++) brd[k][5-k] = CELL_RED;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL diag_down_win got %b want %b", bus.win, WIN_RED); end
  endtask

  task automatic test_draw();
    int cyc, gaps;
    for (int c = 0; c < int'(NUM_COLS); c++)
      for (int r = 0; r < int'(ROWS); r++)
        brd[c][r] = ((((r >> 1) + c) % 2) == 0) ? CELL_RED : CELL_YELLOW;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_DRAW) begin n_fail++; $display("FAIL draw_full_win got %b want %b", bus.win, WIN_DRAW); end
    brd[3][5] = CELL_EMPTY;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_NONE) begin n_fail++; $display("FAIL draw_one_empty_win got %b want %b", bus.win, WIN_NONE); end
  endtask

  task automatic test_change_while_busy();
    int done_cnt, done_at;
    clear_board();
    for (int c = 0; c < 4; c++) brd[c][0] = CELL_RED;
    start_scan();
    done_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 250; n++) begin
      step();
      if (n == 50) bus.change = 1'b1;
      if (n == 51) bus.change = 1'b0;
      if (n == 60) begin
        brd[0][0] = CELL_EMPTY;
        drive_cols();
      end
      if (bus.done) begin
        done_cnt++;
        done_at = n;
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_change_done_count got %0d want 1", done_cnt); end
    n_checks++; if (done_at != 168) begin n_fail++; $display("FAIL busy_change_done_cycle got %0d want 168", done_at); end
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL busy_change_win got %b want %b", bus.win, WIN_RED); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_change_no_requeue got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, gaps;
    clear_board();
    for (int r = 0; r < 4; r++) brd[0][r] = CELL_RED;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL b2b_first_win got %b want %b", bus.win, WIN_RED); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen got %b want 1", bus.done); end
    clear_board();
    for (int r = 1; r < 5; r++) brd[4][r] = CELL_YELLOW;
    start_scan();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
    wait_done(cyc, gaps);
    n_checks++; if (cyc != 168) begin n_fail++; $display("FAIL b2b_latency got %0d want 168", cyc); end
    n_checks++; if (bus.win !== WIN_YELLOW) begin n_fail++; $display("FAIL b2b_second_win got %b want %b", bus.win, WIN_YELLOW); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, gaps;
    clear_board();
    for (int c = 3; c < 7; c++) brd[c][2] = CELL_RED;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL rst_mid_setup_win got %b want %b", bus.win, WIN_RED); end
    start_scan();
    for (int n = 1; n < 80; n++) step();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.win !== WIN_NONE) begin n_fail++; $display("FAIL rst_mid_win got %b want %b", bus.win, WIN_NONE); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
    step();
    step();
    reset = 1'b0;
    step();
    clear_board();
    for (int r = 0; r < 4; r++) brd[5][r] = CELL_YELLOW;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (cyc != 168) begin n_fail++; $display("FAIL rst_mid_after_latency got %0d want 168", cyc); end
    n_checks++; if (bus.win !== WIN_YELLOW) begin n_fail++; $display("FAIL rst_mid_after_win got %b want %b", bus.win, WIN_YELLOW); end
  endtask

  task automatic test_first_hit_and_illegal();
    int cyc, gaps;
    clear_board();
    for (int r = 0; r < 4; r++) begin
      brd[0][r] = CELL_RED;
      brd[6][r] = CELL_YELLOW;
    end
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_RED) begin n_fail++; $display("FAIL first_hit_red got %b want %b", bus.win, WIN_RED); end
    clear_board();
    for (int r = 2; r < 6; r++) brd[0][r] = CELL_YELLOW;
    for (int c = 3; c < 7; c++) brd[c][0] = CELL_RED;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_YELLOW) begin n_fail++; $display("FAIL first_hit_yellow got %b want %b", bus.win, WIN_YELLOW); end
    clear_board();
    for (int r = 0; r < 4; r++) brd[3][r] = CELL_ILLEGAL;
    start_scan();
    wait_done(cyc, gaps);
    n_checks++; if (bus.win !== WIN_NONE) begin n_fail++; $display("FAIL illegal_run_win got %b want %b", bus.win, WIN_NONE); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_vertical();
    test_diagonal();
    test_draw();
    test_change_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_first_hit_and_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_win_scanner.md
Name: board_win_scanner

Overview:
- Reader side of the board store: consumes the seven 12-bit column vectors that the column/matrix blocks drive, and produces the `win` code that those blocks take back in.
- On each `change` pulse it snapshots the board. It then walks every 4-cell window sequentially, one anchor/direction pair per cycle, and reports no-win, red win, yellow win or draw.
- It sits between the board store and the game-control FSM.

Parameters:
- ROWS, 6, cells per column. Column port width is 2*ROWS.
- CONNECT, 4, run length that constitutes a win.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- change  input  1  single-cycle pulse: board was just updated, start a scan.
- col1..col7  input  12 each  column cells. Bits [2r+1:2r] are row r; row 0 is the bottom.
- win  output  2  result: 00 none, 01 red, 10 yellow, 11 draw. Held between scans.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when `win` has just been updated.

Behaviour:
- Cell encoding: 00 empty, 01 red (player_colour 0), 10 yellow (player_colour 1), 11 illegal (never matches).
- Reset (async, active-high): state IDLE, win=00, busy=0, done=0, scan index=0, found flag clear. Snapshot register is cleared to all-empty.
- FSM states: IDLE, SCAN.
- IDLE:
  - `change`=1 at edge E0: copy col1..col7 into the snapshot, idx<=0, found<=0, state<=SCAN, busy<=1.
  - Otherwise stay in IDLE with done=0.
- SCAN, one step per edge:
  - idx runs 0..7*ROWS*4-1 (0..167 at defaults).
  - anchor = idx/4, taken column-major: column c=anchor/ROWS (0..6), row r=anchor%ROWS.
  - dir = idx%4:
    - 0: horizontal (+c)
    - 1: vertical (+r)
    - 2: diagonal (+c,+r)
    - 3: diagonal (+c,-r)
  - A window is skipped if any of its CONNECT cells falls off the board.
  - Hit: all CONNECT cells are equal and are 01 or 10. On the first hit, latch that colour and set found.
  - Later hits in the same scan are ignored; the first hit in scan order wins, including on illegal dual-winner boards.
- Completion: the edge that evaluates the last idx (E168) does all of the following:
  - win <= found colour; else 11 if no snapshot cell is 00; else 00.
  - done <= 1 for exactly one cycle.
  - busy <= 0, state <= IDLE.
- Latency: `change` at E0 gives the result visible after E168. Latency is fixed at 7*ROWS*4 cycles, with no early exit.
- `change` while busy: ignored. The scan continues on the original snapshot, and no queued scan follows.
- `change` in the same cycle that done is high: accepted normally, starting a new scan at that edge.
- Column inputs may change freely during SCAN; only the snapshot is examined.
- Reset mid-scan: immediate return to reset values. The partial result is discarded and the old `win` is not preserved.
- `win` is stable except at the completion edge or reset.

Decomposition:
- Shared package `c4_pkg` holds:
  - cell constants CELL_EMPTY/RED/YELLOW
  - win codes WIN_NONE/RED/YELLOW/DRAW
  - NUM_COLS=7, ROWS, CONNECT
  - direction enum DIR_H/V/DU/DD
  - FSM state typedef
- Sub-module `window_check`: combinational. Inputs are CONNECT cell codes; outputs are hit and colour. The scanner instantiates it once and muxes cells from the snapshot using anchor, dir and offset.

Test Plan:
- Empty board, pulse change → busy high 168 cycles, done pulses after E168, win=00.
- col2 rows 0-3 = 01, rest empty → win=01. Repeat with col7 rows 2-5 = 10 (top edge) → win=10.
- Yellow diagonal (c,r)=(3,0),(4,1),(5,2),(6,3) set to 10 (board-edge windows) → win=10. Also check a down-right diagonal (0,5),(1,4),(2,3),(3,2) of 01 → win=01.
- Full board with cell(c,r)=01 if ((r>>1)+c) even else 10 (no four in any direction) → win=11. Then clear one cell to 00 and rescan → win=00.
- Red horizontal row 0 cols 0-3. Pulse change, then pulse change again at cycle 50 and alter col1 at cycle 60 → only one done, at E168; win=01 from the original snapshot.
- Set win=01 via a scan, start a new scan, assert reset at cycle 80 → win=00, busy=0, done=0 immediately. After release, a new change completes normally.
